// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC iteration scheduler: state encoding and default sizes.
package ldpc_pkg;
    localparam int ITER_W_DEF  = 5;
    localparam int TIMEOUT_DEF = 1023;
    localparam int TO_W_DEF    = 10;

    typedef enum logic [2:0] {
        IDLE,
        CNP,
        GAP_C,
        VNP,
        GAP_V,
        FIN
    } state_t;
endpackage

// File: rtl/ldpc_phase_wdog.sv
// Per-phase watchdog: counts cycles while enabled and flags the cycle in which
// the phase reaches TIMEOUT cycles.
module ldpc_phase_wdog #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

    // r_cnt holds cycles already spent; the current cycle is number r_cnt+1.
    assign o_expire = i_en && (r_cnt == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC iteration scheduler: alternates CNP/VNP passes with a ce-low gap between
// them, counts iterations, flags the final VNP pass and reports completion.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int ITER_W  = ITER_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ITER_W-1:0] i_max_iter,
    input  logic              i_early_stop_en,
    input  logic              i_parity_ok,
    input  logic              i_cnp_finish,
    input  logic              i_vnp_finish,
    output logic              o_ce,
    output logic              o_cnp_on,
    output logic              o_last_iteration,
    output logic              o_busy,
    output logic              o_done,
    output logic [ITER_W-1:0] o_iter_cnt,
    output logic              o_timeout_err
);
    state_t            r_state;
    logic [ITER_W-1:0] r_lim;
    logic              r_es;
    logic              r_stop;
    logic              r_ce, r_cnp_on, r_last, r_busy, r_done, r_to_err;
    logic [ITER_W-1:0] r_iter;

    logic              w_wd_en;
    logic              w_expire;
    logic [ITER_W-1:0] w_lim_in;
    logic              w_hit_lim;
    logic [ITER_W-1:0] w_iter_inc;

    assign w_wd_en    = (r_state == CNP) || (r_state == VNP);
    assign w_lim_in   = (i_max_iter == '0) ? ITER_W'(1) : i_max_iter;
    // Extra bit keeps the compare exact even when iter_cnt is all-ones.
    assign w_hit_lim  = ({1'b0, r_iter} + (ITER_W+1)'(1)) == {1'b0, r_lim};
    assign w_iter_inc = (&r_iter) ? r_iter : r_iter + 1'b1;

    ldpc_phase_wdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!w_wd_en),
        .i_en     (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_lim    <= ITER_W'(1);
            r_es     <= 1'b0;
            r_stop   <= 1'b0;
            r_ce     <= 1'b0;
            r_cnp_on <= 1'b1;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_iter   <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_lim    <= w_lim_in;
                        r_es     <= i_early_stop_en;
                        r_iter   <= '0;
                        r_to_err <= 1'b0;
                        r_busy   <= 1'b1;
                        r_ce     <= 1'b1;
                        r_cnp_on <= 1'b1;
                        r_state  <= CNP;
                    end
                end
                CNP: begin
                    if (i_cnp_finish) begin
                        r_stop  <= w_hit_lim || (r_es && i_parity_ok);
                        r_ce    <= 1'b0;
                        r_state <= GAP_C;
                    end else if (w_expire) begin
                        r_to_err <= 1'b1;
                        r_ce     <= 1'b0;
                        r_state  <= FIN;
                    end
                end
                GAP_C: begin
                    r_last   <= r_stop;
                    r_ce     <= 1'b1;
                    r_cnp_on <= 1'b0;
                    r_state  <= VNP;
                end
                VNP: begin
                    if (i_vnp_finish) begin
                        r_iter  <= w_iter_inc;
                        r_ce    <= 1'b0;
                        r_state <= r_last ? FIN : GAP_V;
                    end else if (w_expire) begin
                        r_to_err <= 1'b1;
                        r_ce     <= 1'b0;
                        r_state  <= FIN;
                    end
                end
                GAP_V: begin
                    r_cnp_on <= 1'b1;
                    r_ce     <= 1'b1;
                    r_state  <= CNP;
                end
                FIN: begin
                    r_ce     <= 1'b0;
                    r_cnp_on <= 1'b1;
                    r_last   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ce             = r_ce;
    assign o_cnp_on         = r_cnp_on;
    assign o_last_iteration = r_last;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_iter_cnt       = r_iter;
    assign o_timeout_err    = r_to_err;
endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl: plays the cnp/vnp pair and checks the
// scheduler's phase sequence, iteration count, done pulse and error flag.
module tb_ldpc_iter_ctrl;
    localparam int ITER_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [ITER_W-1:0] i_max_iter = '0;
    logic              i_early_stop_en = 1'b0;
    logic              i_parity_ok = 1'b0;
    logic              i_cnp_finish = 1'b0;
    logic              i_vnp_finish = 1'b0;
    logic              o_ce, o_cnp_on, o_last_iteration, o_busy, o_done, o_timeout_err;
    logic [ITER_W-1:0] o_iter_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    ldpc_iter_ctrl #(.ITER_W(ITER_W), .TIMEOUT(1023), .TO_W(10)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (i_start),
        .i_max_iter       (i_max_iter),
        .i_early_stop_en  (i_early_stop_en),
        .i_parity_ok      (i_parity_ok),
        .i_cnp_finish     (i_cnp_finish),
        .i_vnp_finish     (i_vnp_finish),
        .o_ce             (o_ce),
        .o_cnp_on         (o_cnp_on),
        .o_last_iteration (o_last_iteration),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_iter_cnt       (o_iter_cnt),
        .o_timeout_err    (o_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_start(input logic [ITER_W-1:0] mi, input logic es);
        @(negedge clk);
        i_max_iter = mi; i_early_stop_en = es; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
    endtask

    // Wait for the CNP phase, optionally inject a stray vnp_finish, then finish.
    task automatic do_cnp(input string tag, input int dly, input logic par, input logic inj);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (o_ce && o_cnp_on) begin seen = 1; break; end
            @(negedge clk);
        end
        chk({tag, "_cnp_seen"}, seen, 1);
        chk({tag, "_cnp_last"}, o_last_iteration, 0);
        for (int i = 1; i < dly; i++) begin
            if (inj && i == dly / 2) begin
                i_vnp_finish = 1'b1; @(negedge clk); i_vnp_finish = 1'b0;
                chk({tag, "_cnp_stay"}, {o_ce, o_cnp_on}, 2'b11);
            end else
                @(negedge clk);
        end
        i_cnp_finish = 1'b1; i_parity_ok = par;
        @(negedge clk);
        i_cnp_finish = 1'b0; i_parity_ok = 1'b0;
        chk({tag, "_cnp_ce_drop"}, o_ce, 0);
    endtask

    // Wait for the VNP phase, check last_iteration, optionally inject a start.
    task automatic do_vnp(input string tag, input int dly, input logic exp_last, input logic inj);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (o_ce && !o_cnp_on) begin seen = 1; break; end
            @(negedge clk);
        end
        chk({tag, "_vnp_seen"}, seen, 1);
        chk({tag, "_vnp_last"}, o_last_iteration, exp_last);
        for (int i = 1; i < dly; i++) begin
            if (inj && i == dly / 2) begin
                i_max_iter = 1; i_start = 1'b1; @(negedge clk); i_start = 1'b0;
                chk({tag, "_vnp_stay"}, {o_ce, o_cnp_on}, 2'b10);
            end else
                @(negedge clk);
        end
        chk({tag, "_vnp_last_end"}, o_last_iteration, exp_last);
        i_vnp_finish = 1'b1;
        @(negedge clk);
        i_vnp_finish = 1'b0;
        chk({tag, "_vnp_ce_drop"}, o_ce, 0);
    endtask

    task automatic wait_done(input string tag, input int exp_iter, input logic exp_to);
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (o_done) begin seen = 1; break; end
            @(negedge clk);
        end
        chk({tag, "_done"}, seen, 1);
        chk({tag, "_iter"}, o_iter_cnt, exp_iter);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_to_err"}, o_timeout_err, exp_to);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, o_done, 0);
        chk({tag, "_idle_ce"}, {o_ce, o_cnp_on}, 2'b01);
    endtask

    initial begin
        int ce_cycles;
        #12;
        chk("rst_ce", o_ce, 0);
        chk("rst_cnp_on", o_cnp_on, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_iter", o_iter_cnt, 0);
        chk("rst_to", o_timeout_err, 0);
        rst_n = 1'b1;

        // Finishes in IDLE are ignored.
        @(negedge clk);
        i_cnp_finish = 1'b1; i_vnp_finish = 1'b1;
        @(negedge clk);
        i_cnp_finish = 1'b0; i_vnp_finish = 1'b0;
        chk("idle_fin_ign", {o_ce, o_busy}, 2'b00);

        // Three full iterations; parity_ok with es=0 must not stop early.
        do_start(3, 0);
        do_cnp("t1i1", 20, 1, 0); do_vnp("t1i1", 20, 0, 0);
        do_cnp("t1i2", 20, 0, 0); do_vnp("t1i2", 20, 0, 0);
        do_cnp("t1i3", 20, 0, 0); do_vnp("t1i3", 20, 1, 0);
        wait_done("t1", 3, 0);

        // Early stop on parity at the second CNP pass.
        do_start(10, 1);
        do_cnp("t2i1", 8, 0, 0); do_vnp("t2i1", 8, 0, 0);
        do_cnp("t2i2", 8, 1, 0); do_vnp("t2i2", 8, 1, 0);
        wait_done("t2", 2, 0);

        // max_iter=0 behaves as 1.
        do_start(0, 0);
        do_cnp("t3", 5, 0, 0); do_vnp("t3", 5, 1, 0);
        wait_done("t3", 1, 0);

        // Watchdog: CNP never finishes.
        do_start(4, 0);
        ce_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!o_ce) break;
            ce_cycles++;
            @(negedge clk);
        end
        chk("t4_cnp_cycles", ce_cycles, 1023);
        wait_done("t4", 0, 1);
        do_start(1, 0);
        chk("t4_to_clear", o_timeout_err, 0);
        do_cnp("t4b", 4, 0, 0); do_vnp("t4b", 4, 1, 0);
        wait_done("t4b", 1, 0);

        // Stray vnp_finish in CNP and start in VNP are ignored.
        do_start(2, 0);
        do_cnp("t5i1", 10, 0, 1); do_vnp("t5i1", 10, 0, 1);
        do_cnp("t5i2", 10, 0, 1); do_vnp("t5i2", 10, 1, 0);
        wait_done("t5", 2, 0);

        // Asynchronous reset during the second VNP pass.
        do_start(3, 0);
        do_cnp("t6i1", 6, 0, 0); do_vnp("t6i1", 6, 0, 0);
        do_cnp("t6i2", 6, 0, 0);
        repeat (3) @(negedge clk);
        chk("t6_pre_rst_vnp", {o_ce, o_cnp_on, o_busy}, 3'b101);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_ce", o_ce, 0);
        chk("t6_rst_cnp_on", o_cnp_on, 1);
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_iter", o_iter_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1, 0);
        do_cnp("t6b", 5, 0, 0); do_vnp("t6b", 5, 1, 0);
        wait_done("t6b", 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ldpc_iter_ctrl.md
Name: ldpc_iter_ctrl

Overview:
- Iteration scheduler for the LDPC decoder core.
- Alternates the check-node processor (CNP) and the variable-node processor (VNP) phases over the shared message memory, and counts iterations.
- Flags the final VNP pass (result write-back) and reports completion to the host side.
- Sits between the frame-load logic and the cnp/vnp pair; drives their ce / cnp_on / last_iteration controls.

Parameters:
- ITER_W, 5, width of the iteration count and limit.
- TIMEOUT, 1023, maximum cycles allowed in one phase before timeout_err.
- TO_W, 10, width of the phase watchdog counter (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; frame is loaded, begin decoding. Ignored unless IDLE.
- max_iter  in  ITER_W  iteration limit, sampled on accepted start; 0 treated as 1.
- early_stop_en  in  1  enable parity-based early termination, sampled on start.
- parity_ok  in  1  all checks satisfied; sampled only in the cycle cnp_finish is high.
- cnp_finish  in  1  CNP end-of-pass pulse.
- vnp_finish  in  1  VNP end-of-pass pulse (VNP process_finish).
- ce  out  1  decoder core enable.
- cnp_on  out  1  1 = CNP phase (VNP held cleared); 0 = VNP phase.
- last_iteration  out  1  high for the whole final VNP pass.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- iter_cnt  out  ITER_W  completed iterations of the current or last frame.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared by next accepted start.

Behaviour:
- All outputs are registered.
- Reset values: ce=0, cnp_on=1, last_iteration=0, busy=0, done=0, iter_cnt=0, timeout_err=0, state=IDLE.

States:
- IDLE: ce=0, cnp_on=1.
  - Accepted start: latch lim=max(max_iter,1) and es=early_stop_en; iter_cnt<=0; timeout_err<=0; busy<=1; go to CNP.
- CNP: ce=1, cnp_on=1.
  - On cnp_finish: latch stop = (iter_cnt+1 == lim) | (es & parity_ok); go to GAP_C.
- GAP_C: one cycle with ce=0.
  - The VNP sees the ce-low clear.
  - last_iteration<=stop; go to VNP.
- VNP: ce=1, cnp_on=0.
  - On vnp_finish: iter_cnt<=iter_cnt+1.
  - If last_iteration: go to FIN. Else go to GAP_V.
- GAP_V: one cycle with ce=0, cnp_on<=1; go to CNP.
- FIN: ce=0, cnp_on=1, last_iteration<=0, busy<=0, done<=1 for one cycle; go to IDLE.

Timing rules:
- ce drops exactly one cycle after a finish pulse, so a VNP never restarts a second pass.
- Phase watchdog:
  - Counter clears on entry to CNP or VNP and increments every cycle in those states.
  - On reaching TIMEOUT: timeout_err<=1; exit through FIN (done pulses, iter_cnt holds).
- Finish pulses are ignored outside their own phase (e.g. vnp_finish in CNP, cnp_finish in VNP, anything in IDLE).
- start while busy is ignored; latched lim and es are unaffected.
- cnp_finish with parity_ok=1 and es=0: no early stop.
- max_iter=1: the first VNP pass is already last_iteration.
- iter_cnt saturates at all-ones; it never wraps.
- Asynchronous reset mid-frame returns to the reset values immediately; the partial frame is abandoned.

Decomposition:
- Shared package ldpc_pkg holds:
  - state enum: IDLE, CNP, GAP_C, VNP, GAP_V, FIN;
  - ITER_W default;
  - TIMEOUT default.
- One natural sub-module: ldpc_phase_wdog. It contains the watchdog counter, with clear / enable inputs and an expire output.

Test Plan:
- max_iter=3, es=0, finishes returned 20 cycles after each phase start:
  - expect CNP,VNP three times;
  - last_iteration high only during the third VNP;
  - done one pulse; iter_cnt=3; busy low after done.
- max_iter=10, es=1, parity_ok=1 at the second cnp_finish:
  - second VNP is last; iter_cnt=2; done pulses.
- max_iter=0:
  - behaves as 1: one CNP, one VNP with last_iteration=1; iter_cnt=1.
- Hold cnp_finish low with TIMEOUT=1023:
  - timeout_err=1 after 1023 CNP cycles; done pulses; iter_cnt=0.
  - Next start clears timeout_err.
- start asserted during VNP, and vnp_finish injected during CNP:
  - both ignored; sequence and iter_cnt unchanged.
- rst_n low mid-VNP of iteration 2:
  - ce=0, cnp_on=1, busy=0, iter_cnt=0 without waiting for a clock edge.
  - A fresh start decodes normally.
